eth_pcs_rx_descrambler: RTL
===========================

ETH_PCS_RX_DESCRAMBLER -- requirements
Module: eth_pcs_rx_descrambler

Interface
REQ-001 Parameter: DESCR_INIT, 58'h0, initial descrambler state loaded on reset.
REQ-002 Widths come from package constants W_DATA=32 and W_SYNC=2.
REQ-003 i_clk  input  1  clock.
REQ-004 i_reset  input  1  reset; synchronous, active-high.
REQ-005 i_valid  input  1  i_data word valid this cycle.
REQ-006 i_hdr_valid  input  1  marks the first word of a 66b block; i_hdr is valid.
REQ-007 i_hdr  input  W_SYNC  sync header from the gearbox.
REQ-008 i_data  input  W_DATA  scrambled payload word; bit0 is received first.
REQ-009 i_rx_lock  input  1  block lock from block sync.
REQ-010 o_valid  output  1  one-cycle pulse; the 64b block is valid.
REQ-011 o_hdr  output  W_SYNC  header of the output block.
REQ-012 o_data  output  64  descrambled block; the first word is in [31:0].
REQ-013 o_hdr_err  output  1  the header of the output block is 2'b00 or 2'b11; qualified by o_valid.
REQ-014 o_align_err  output  1  one-cycle pulse; a partial block was discarded.

Function
REQ-015 Descrambler polynomial SHALL be 1+x^39+x^58, self-synchronizing, 58-bit state S, with S[0] the most recently received bit.
REQ-016 Bits SHALL be processed in order i=0..31 for each word, as follows.
- out[i] = in[i] ^ S[38] ^ S[57].
- Then S = {S[56:0], in[i]}.
- All 32 bits are processed in one cycle.
REQ-017 S SHALL update on every cycle with i_valid=1, regardless of i_rx_lock or assembly state.
- S holds when i_valid=0.
REQ-018 The header SHALL NOT be descrambled; it is passed unchanged to o_hdr.
REQ-019 The assembly FSM SHALL have two states, WAIT_FIRST and HAVE_FIRST.
REQ-020 In WAIT_FIRST, i_valid & i_hdr_valid SHALL store the descrambled word and header, then go to HAVE_FIRST.
- i_valid & !i_hdr_valid: the word is dropped and the state is unchanged.
REQ-021 In HAVE_FIRST, i_valid & !i_hdr_valid SHALL register the output and return to WAIT_FIRST.
- Output is {descrambled word, stored word}.
- o_valid=1 on the next cycle; latency is 1 cycle after the second word.
REQ-022 In HAVE_FIRST, i_valid & i_hdr_valid SHALL discard the stored word and store the new word as first.
- State stays HAVE_FIRST.
- o_align_err pulses on the next cycle.
REQ-023 With i_valid=0, the FSM state and stored data SHALL hold.
- Gearbox stall cycles are tolerated with any gap length.
REQ-024 i_rx_lock=0 SHALL force the FSM to WAIT_FIRST and suppress o_valid and o_align_err.
- The partial block is dropped silently.
REQ-025 o_hdr and o_data SHALL hold their last value when o_valid=0.
REQ-026 o_hdr_err SHALL be computed from the header stored with the block and registered together with o_valid.

Reset
REQ-027 Reset SHALL apply the following values.
- S=DESCR_INIT and FSM=WAIT_FIRST.
- o_valid=0, o_hdr=0, o_data=0, o_hdr_err=0, o_align_err=0.
REQ-028 Reset asserted mid-block SHALL discard the stored word; no o_valid follows the release of reset.

Configuration
REQ-029 The macro ETH_PCS_RX_DESCR_ERR_CNT_EN SHALL control the header error counter.
- Defined: adds output o_hdr_err_cnt [7:0].
- The counter increments on each o_valid & o_hdr_err, saturates at 255, and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Verification
REQ-030 Zero data: S=0, lock=1, words 0x0 (hdr 01) then 0x0 -> one o_valid, o_data=0, o_hdr=01, o_hdr_err=0.
REQ-031 Impulse: S=0, first word 0x00000001 (hdr 10), second 0x0 -> o_data=0x0400_0080_0000_0001, o_hdr=10.
REQ-032 Header error: block with hdr 11 -> o_hdr_err=1.
- With ETH_PCS_RX_DESCR_ERR_CNT_EN defined, 300 such blocks -> o_hdr_err_cnt=255.
REQ-033 Misalignment: two consecutive hdr_valid words then one data word.
- o_align_err pulses once.
- The block is assembled from the 2nd and 3rd words.
REQ-034 Stall and lock: a 3-cycle i_valid=0 gap between block halves gives a correct block.
- Dropping i_rx_lock in HAVE_FIRST gives no o_valid.
- S still matches a reference model afterwards.
REQ-035 Self-sync: random scrambled stream with mismatched initial S.
- All blocks fully received after the first 58 bits match the reference descrambler.

Source files
------------

// File: rtl/eth_pcs_rx_descrambler_if.sv
// Width constants and the receive-side bus between gearbox/block sync and the descrambler.
// The o_hdr_err_cnt signal exists only when ETH_PCS_RX_DESCR_ERR_CNT_EN is defined.
package eth_pcs_rx_descrambler_pkg;
  localparam int W_DATA = 32;
  localparam int W_SYNC = 2;
endpackage

interface eth_pcs_rx_descrambler_if;
  import eth_pcs_rx_descrambler_pkg::*;

  logic                  i_valid;
  logic                  i_hdr_valid;
  logic [W_SYNC-1:0]     i_hdr;
  logic [W_DATA-1:0]     i_data;
  logic                  i_rx_lock;
  logic                  o_valid;
  logic [W_SYNC-1:0]     o_hdr;
  logic [2*W_DATA-1:0]   o_data;
  logic                  o_hdr_err;
  logic                  o_align_err;
`ifdef ETH_PCS_RX_DESCR_ERR_CNT_EN
  logic [7:0]            o_hdr_err_cnt;

  modport slave (
    input  i_valid, i_hdr_valid, i_hdr, i_data, i_rx_lock,
    output o_valid, o_hdr, o_data, o_hdr_err, o_align_err, o_hdr_err_cnt
  );
  modport master (
    output i_valid, i_hdr_valid, i_hdr, i_data, i_rx_lock,
    input  o_valid, o_hdr, o_data, o_hdr_err, o_align_err, o_hdr_err_cnt
  );
`else
  modport slave (
    input  i_valid, i_hdr_valid, i_hdr, i_data, i_rx_lock,
    output o_valid, o_hdr, o_data, o_hdr_err, o_align_err
  );
  modport master (
    output i_valid, i_hdr_valid, i_hdr, i_data, i_rx_lock,
    input  o_valid, o_hdr, o_data, o_hdr_err, o_align_err
  );
`endif
endinterface

// File: rtl/eth_pcs_rx_descrambler.sv
// 10GBASE-R receive descrambler (1+x^39+x^58) with 2x32b -> 64b block assembly.
// Define ETH_PCS_RX_DESCR_ERR_CNT_EN to add the saturating o_hdr_err_cnt output.
module eth_pcs_rx_descrambler
  import eth_pcs_rx_descrambler_pkg::*;
#(
  parameter logic [57:0] DESCR_INIT = 58'h0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  eth_pcs_rx_descrambler_if.slave   bus
);

  typedef enum logic {WAIT_FIRST, HAVE_FIRST} state_t;

  state_t              state_q, state_d;
  logic [57:0]         s_q, s_d, s_shift;
  logic [W_DATA-1:0]   desc_word;
  logic [W_DATA-1:0]   first_q, first_d;
  logic [W_SYNC-1:0]   first_hdr_q, first_hdr_d;
  logic                hdr_bad;
  logic                o_valid_q, o_valid_d;
  logic [W_SYNC-1:0]   o_hdr_q, o_hdr_d;
  logic [2*W_DATA-1:0] o_data_q, o_data_d;
  logic                o_hdr_err_q, o_hdr_err_d;
  logic                o_align_err_q, o_align_err_d;

  // Bit-serial self-synchronising descrambler unrolled over the whole word, LSB first.
  always_comb begin
    s_shift   = s_q;
    desc_word = '0;
    for (int i = 0; i < W_DATA; i++) begin
      desc_word[i] = bus.i_data[i] ^ s_shift[38] ^ s_shift[57];
      s_shift      = {s_shift[56:0], bus.i_data[i]};
    end
    s_d = bus.i_valid ? s_shift : s_q;
  end

  assign hdr_bad = (first_hdr_q == 2'b00) || (first_hdr_q == 2'b11);

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    first_hdr_d   = first_hdr_q;
    o_valid_d     = 1'b0;
    o_align_err_d = 1'b0;
    o_hdr_d       = o_hdr_q;
    o_data_d      = o_data_q;
    o_hdr_err_d   = o_hdr_err_q;
    // Loss of lock drops any half-assembled block without flagging it.
    if (!bus.i_rx_lock) begin
      state_d = WAIT_FIRST;
    end else if (bus.i_valid) begin
      case (state_q)
        WAIT_FIRST: begin
          if (bus.i_hdr_valid) begin
            first_d     = desc_word;
            first_hdr_d = bus.i_hdr;
            state_d     = HAVE_FIRST;
          end
        end
        HAVE_FIRST: begin
          if (bus.i_hdr_valid) begin
            first_d       = desc_word;
            first_hdr_d   = bus.i_hdr;
            o_align_err_d = 1'b1;
          end else begin
            o_valid_d   = 1'b1;
            o_data_d    = {desc_word, first_q};
            o_hdr_d     = first_hdr_q;
            o_hdr_err_d = hdr_bad;
            state_d     = WAIT_FIRST;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s_q           <= DESCR_INIT;
      state_q       <= WAIT_FIRST;
      first_q       <= '0;
      first_hdr_q   <= '0;
      o_valid_q     <= 1'b0;
      o_hdr_q       <= '0;
      o_data_q      <= '0;
      o_hdr_err_q   <= 1'b0;
      o_align_err_q <= 1'b0;
    end else begin
      s_q           <= s_d;
      state_q       <= state_d;
      first_q       <= first_d;
      first_hdr_q   <= first_hdr_d;
      o_valid_q     <= o_valid_d;
      o_hdr_q       <= o_hdr_d;
      o_data_q      <= o_data_d;
      o_hdr_err_q   <= o_hdr_err_d;
      o_align_err_q <= o_align_err_d;
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_hdr       = o_hdr_q;
  assign bus.o_data      = o_data_q;
  assign bus.o_hdr_err   = o_hdr_err_q;
  assign bus.o_align_err = o_align_err_q;

`ifdef ETH_PCS_RX_DESCR_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts bad-header blocks as they appear on the output, sticking at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (o_valid_q && o_hdr_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_hdr_err_cnt = err_cnt_q;
`endif

endmodule
